// File: rtl/uart_cmd_ctrl_if.sv
// Client command/response and UART FIFO signals shared between uart_cmd_ctrl and its environment.
interface uart_cmd_ctrl_if;
    logic [1:0]  req;
    logic [15:0] cmd_data;
    logic [1:0]  cmd_valid;
    logic [1:0]  cmd_ready;
    logic [7:0]  rsp_data;
    logic [1:0]  rsp_valid;
    logic [1:0]  done;
    logic [1:0]  status;
    logic [1:0]  grant;
    logic        busy;
    logic        wr_uart;
    logic [7:0]  w_data;
    logic        tx_full;
    logic        rd_uart;
    logic [7:0]  r_data;
    logic        rx_empty;
    logic        e_parity;
    logic        e_frame;
    logic        e_rxof;

    modport master (
        output req, cmd_data, cmd_valid, tx_full, r_data, rx_empty, e_parity, e_frame, e_rxof,
        input  cmd_ready, rsp_data, rsp_valid, done, status, grant, busy, wr_uart, w_data, rd_uart
    );

    modport slave (
        input  req, cmd_data, cmd_valid, tx_full, r_data, rx_empty, e_parity, e_frame, e_rxof,
        output cmd_ready, rsp_data, rsp_valid, done, status, grant, busy, wr_uart, w_data, rd_uart
    );
endinterface

// File: rtl/uart_cmd_ctrl.sv
// Round-robin transaction controller sharing one FIFO-buffered UART between two command clients.
// A transaction streams a command up to TERM_TX, then returns RX bytes until PROMPT, timeout or error.
module uart_cmd_ctrl #(
    parameter logic [7:0]  TERM_TX = 8'h0D,
    parameter logic [7:0]  PROMPT  = 8'h3E,
    parameter int unsigned TIMEOUT = 500000,
    parameter int unsigned TO_W    = 20
) (
    input  logic           clk,
    input  logic           reset,
    uart_cmd_ctrl_if.slave bus
);
    localparam int unsigned ST_W = 3;
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FLUSH = 3'd1;
    localparam logic [2:0] S_SEND  = 3'd2;
    localparam logic [2:0] S_RECV  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [1:0] ST_OK  = 2'b00;
    localparam logic [1:0] ST_TO  = 2'b01;
    localparam logic [1:0] ST_ERR = 2'b10;

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    logic [ST_W-1:0] state_q, state_d;
    logic [1:0]      grant_q, grant_d;
    logic            busy_q, busy_d;
    logic            last_q, last_d;
    logic [TO_W-1:0] timer_q, timer_d;
    logic [7:0]      rsp_data_q, rsp_data_d;
    logic [1:0]      rsp_valid_q, rsp_valid_d;
    logic [1:0]      done_q, done_d;
    logic [1:0]      status_q, status_d;

    logic            wr_uart_c;
    logic            rd_uart_c;
    logic [1:0]      cmd_ready_c;
    logic [7:0]      w_data_c;

    logic            g;
    logic            pref;
    logic            win;
    logic [7:0]      cmd_byte;
    logic            rx_err;

    // Granted client index and its command lane
    assign g        = grant_q[1];
    assign cmd_byte = g ? bus.cmd_data[15:8] : bus.cmd_data[7:0];
    assign rx_err   = bus.e_parity | bus.e_frame | bus.e_rxof;

    // The client that did not own the last transaction is preferred
    assign pref = ~last_q;
    assign win  = bus.req[pref] ? pref : last_q;

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        last_d      = last_q;
        timer_d     = timer_q;
        rsp_data_d  = rsp_data_q;
        rsp_valid_d = 2'b00;
        done_d      = 2'b00;
        status_d    = status_q;
        wr_uart_c   = 1'b0;
        rd_uart_c   = 1'b0;
        cmd_ready_c = 2'b00;
        w_data_c    = 8'h00;

        case (state_q)
            S_IDLE: begin
                if (bus.req != 2'b00) begin
                    grant_d = win ? 2'b10 : 2'b01;
                    state_d = S_FLUSH;
                end
            end

            // Stale RX bytes from a previous exchange are dropped before the command goes out
            S_FLUSH: begin
                if (!bus.rx_empty) begin
                    rd_uart_c = 1'b1;
                end else begin
                    state_d = S_SEND;
                end
            end

            S_SEND: begin
                cmd_ready_c[g] = ~bus.tx_full;
                if (bus.cmd_valid[g] && !bus.tx_full) begin
                    wr_uart_c = 1'b1;
                    w_data_c  = cmd_byte;
                    if (cmd_byte == TERM_TX) begin
                        timer_d = '0;
                        state_d = S_RECV;
                    end
                end
            end

            // Error beats prompt; a byte in the timeout cycle beats the timeout
            S_RECV: begin
                timer_d = timer_q + TO_W'(1);
                if (!bus.rx_empty) begin
                    rd_uart_c = 1'b1;
                    timer_d   = '0;
                end
                if (rx_err) begin
                    state_d  = S_DONE;
                    status_d = ST_ERR;
                    done_d   = grant_q;
                end else if (!bus.rx_empty) begin
                    if (bus.r_data == PROMPT) begin
                        state_d  = S_DONE;
                        status_d = ST_OK;
                        done_d   = grant_q;
                    end else begin
                        rsp_data_d  = bus.r_data;
                        rsp_valid_d = grant_q;
                    end
                end else if (timer_q == TO_LAST) begin
                    state_d  = S_DONE;
                    status_d = ST_TO;
                    done_d   = grant_q;
                end
            end

            S_DONE: begin
                last_d  = g;
                grant_d = 2'b00;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
                grant_d = 2'b00;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            grant_q     <= 2'b00;
            busy_q      <= 1'b0;
            last_q      <= 1'b1;
            timer_q     <= '0;
            rsp_data_q  <= 8'h00;
            rsp_valid_q <= 2'b00;
            done_q      <= 2'b00;
            status_q    <= ST_OK;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            busy_q      <= busy_d;
            last_q      <= last_d;
            timer_q     <= timer_d;
            rsp_data_q  <= rsp_data_d;
            rsp_valid_q <= rsp_valid_d;
            done_q      <= done_d;
            status_q    <= status_d;
        end
    end

    assign bus.grant     = grant_q;
    assign bus.busy      = busy_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.done      = done_q;
    assign bus.status    = status_q;
    assign bus.wr_uart   = wr_uart_c;
    assign bus.rd_uart   = rd_uart_c;
    assign bus.cmd_ready = cmd_ready_c;
    assign bus.w_data    = w_data_c;
endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Bench for uart_cmd_ctrl: queue-backed UART stub, randomized command/response traffic and a
// transaction-level model (bytes up to terminator out, bytes before prompt back, round-robin owner).
module tb_uart_cmd_ctrl;
    localparam int unsigned TB_TIMEOUT = 100;
    localparam logic [7:0]  TERM       = 8'h0D;
    localparam logic [7:0]  PRM        = 8'h3E;

    logic clk = 1'b0;
    logic reset;

    uart_cmd_ctrl_if bus ();

    uart_cmd_ctrl #(
        .TERM_TX (TERM),
        .PROMPT  (PRM),
        .TIMEOUT (TB_TIMEOUT),
        .TO_W    (20)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // RX FIFO stub: read-ahead head, popped on rd_uart
    logic [7:0] rx_mem [64];
    int rx_wr = 0;
    int rx_rd = 0;
    assign bus.r_data   = rx_mem[rx_rd[5:0]];
    assign bus.rx_empty = (rx_wr == rx_rd);
    always @(posedge clk) if (bus.rd_uart) rx_rd <= rx_rd + 1;

    // Monitor: logs UART writes, responses and done pulses away from the active edge
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] tx_log[$];
    logic [8:0] rsp_log[$];
    logic [2:0] done_log[$];
    int term_edge = 0;
    int done_edge = 0;
    int pops = 0;
    int bad = 0;

    always @(negedge clk) begin
        if (bus.wr_uart) begin
            tx_log.push_back(bus.w_data);
            if (bus.w_data == TERM) term_edge = cyc + 1;
        end
        if (bus.rd_uart) pops++;
        if (bus.rsp_valid != 2'b00) rsp_log.push_back({bus.rsp_valid[1], bus.rsp_data});
        if (bus.done != 2'b00) begin
            done_log.push_back({bus.done[1], bus.status});
            done_edge = cyc;
        end
        if (bus.rsp_valid == 2'b11 || bus.done == 2'b11 ||
            (bus.rsp_valid & ~bus.grant) != 2'b00 || (bus.done & ~bus.grant) != 2'b00 ||
            (bus.cmd_ready & ~bus.grant) != 2'b00)
            bad++;
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        rx_mem[rx_wr[5:0]] = b;
        rx_wr++;
    endtask

    // Transaction model
    logic [7:0] cmd_q[$];
    logic [7:0] pay_q[$];
    int last_owner = 1;

    function automatic int arb(input logic [1:0] r, input int last);
        if (r[1-last]) return 1 - last;
        return last;
    endfunction

    task automatic gen(input int ncmd, input int npay);
        logic [7:0] b;
        cmd_q.delete();
        pay_q.delete();
        for (int i = 0; i < ncmd; i++) begin
            do b = 8'($urandom); while (b == TERM);
            cmd_q.push_back(b);
        end
        cmd_q.push_back(TERM);
        for (int i = 0; i < npay; i++) begin
            do b = 8'($urandom); while (b == PRM);
            pay_q.push_back(b);
        end
    endtask

    // mode: 0 prompt-terminated, 1 silent (timeout), 2 receive error
    task automatic run_txn(input int c, input int mode, input int stall_at, input int stale);
        logic [1:0] oh;
        logic [1:0] exp_st;
        int tx_base, rsp_base, dn_base, pop_base, exp_pops, viol, k;
        bit seen, acc;
        oh       = (c == 1) ? 2'b10 : 2'b01;
        exp_st   = (mode == 0) ? 2'b00 : ((mode == 1) ? 2'b01 : 2'b10);
        tx_base  = tx_log.size();
        rsp_base = rsp_log.size();
        dn_base  = done_log.size();
        pop_base = pops;
        exp_pops = stale + ((mode == 1) ? 0 : pay_q.size() + 1);

        bus.req[c] = 1'b1;
        for (k = 0; k < 50; k++) begin
            @(negedge clk);
            if (bus.grant == oh) break;
        end
        chk("grant", 32'(bus.grant), 32'(oh));
        chk("busy", 32'(bus.busy), 32'd1);
        step();
        bus.req[c] = 1'b0;
        bus.cmd_valid[1-c] = 1'b1;

        for (int i = 0; i < cmd_q.size(); i++) begin
            acc = 1'b0;
            if ($urandom_range(0, 3) == 0) begin
                bus.cmd_valid[c] = 1'b0;
                repeat ($urandom_range(1, 2)) step();
            end
            bus.cmd_data[8*c +: 8]     = cmd_q[i];
            bus.cmd_data[8*(1-c) +: 8] = 8'($urandom);
            bus.cmd_valid[c]           = 1'b1;
            if (i == stall_at) begin
                viol = 0;
                bus.tx_full = 1'b1;
                repeat (10) begin
                    @(negedge clk);
                    if (bus.cmd_ready != 2'b00 || bus.wr_uart) viol++;
                end
                step();
                bus.tx_full = 1'b0;
                @(negedge clk);
                chk("stall_quiet", 32'(viol), 32'd0);
                chk("stall_release_wr", 32'(bus.wr_uart), 32'd1);
                chk("stall_release_data", 32'(bus.w_data), 32'(cmd_q[i]));
                acc = 1'b1;
            end else begin
                for (k = 0; k < 100; k++) begin
                    @(negedge clk);
                    if (bus.cmd_ready[c]) begin
                        acc = 1'b1;
                        break;
                    end
                end
            end
            if (i == 0 && stale > 0) chk("flush_before_send", 32'(rx_wr - rx_rd), 32'd0);
            chk("cmd_accept", 32'(acc), 32'd1);
            step();
        end
        bus.cmd_valid = 2'b00;

        if (mode != 1) begin
            foreach (pay_q[i]) begin
                push(pay_q[i]);
                repeat ($urandom_range(0, 2)) step();
            end
        end
        if (mode == 0) push(PRM);

        seen = 1'b0;
        if (mode == 2) begin
            repeat (pay_q.size() + 3) step();
            if ($urandom_range(0, 1) == 1) push(PRM);
            else push(8'h5A);
            case ($urandom_range(0, 2))
                0:       bus.e_parity = 1'b1;
                1:       bus.e_frame  = 1'b1;
                default: bus.e_rxof   = 1'b1;
            endcase
            step();
            bus.e_parity = 1'b0;
            bus.e_frame  = 1'b0;
            bus.e_rxof   = 1'b0;
            @(negedge clk);
            chk("err_done_next_cycle", 32'(bus.done), 32'(oh));
            seen = (bus.done != 2'b00);
        end else begin
            for (k = 0; k < 400; k++) begin
                @(negedge clk);
                if (bus.done != 2'b00) begin
                    seen = 1'b1;
                    break;
                end
            end
        end
        chk("done_seen", 32'(seen), 32'd1);
        chk("done_vec", 32'(bus.done), 32'(oh));
        chk("status", 32'(bus.status), 32'(exp_st));
        @(negedge clk);
        chk("grant_idle", 32'(bus.grant), 32'd0);
        chk("busy_idle", 32'(bus.busy), 32'd0);
        chk("status_held", 32'(bus.status), 32'(exp_st));
        if (mode == 1) chk("timeout_latency", 32'(done_edge - term_edge), 32'(TB_TIMEOUT));

        chk("done_count", 32'(done_log.size() - dn_base), 32'd1);
        chk("tx_count", 32'(tx_log.size() - tx_base), 32'(cmd_q.size()));
        for (int i = 0; i < cmd_q.size(); i++)
            if (tx_base + i < tx_log.size()) chk("tx_byte", 32'(tx_log[tx_base+i]), 32'(cmd_q[i]));
        chk("rsp_count", 32'(rsp_log.size() - rsp_base), 32'(pay_q.size()));
        for (int i = 0; i < pay_q.size(); i++)
            if (rsp_base + i < rsp_log.size())
                chk("rsp_byte", 32'(rsp_log[rsp_base+i]), 32'({c[0], pay_q[i]}));
        chk("rx_pops", 32'(pops - pop_base), 32'(exp_pops));
        chk("rx_drained", 32'(rx_wr - rx_rd), 32'd0);
        last_owner = c;
        step();
    endtask

    initial begin
        int c;
        int m;
        int base_dn;
        int k;
        bus.req       = 2'b00;
        bus.cmd_data  = 16'h0000;
        bus.cmd_valid = 2'b00;
        bus.tx_full   = 1'b0;
        bus.e_parity  = 1'b0;
        bus.e_frame   = 1'b0;
        bus.e_rxof    = 1'b0;
        reset         = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_grant", 32'(bus.grant), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_rsp_data", 32'(bus.rsp_data), 32'd0);
        chk("rst_status", 32'(bus.status), 32'd0);
        chk("rst_wr_rd", 32'({bus.wr_uart, bus.rd_uart}), 32'd0);
        chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
        chk("rst_w_data", 32'(bus.w_data), 32'd0);
        step();
        reset = 1'b1;
        step();

        // Fixed AT-style exchange on client 0
        cmd_q = '{8'h41, 8'h54, 8'h0D};
        pay_q = '{8'h4F, 8'h4B};
        c = arb(2'b01, last_owner);
        run_txn(c, 0, -1, 0);

        // Stale RX bytes are flushed before the command
        push(8'h55);
        push(8'h55);
        step();
        c = arb(2'b10, last_owner);
        gen(3, 2);
        run_txn(c, 0, -1, 2);

        // TX FIFO back-pressure mid-command
        c = int'($urandom_range(0, 1));
        gen(4, 3);
        run_txn(arb(c == 1 ? 2'b10 : 2'b01, last_owner), 0, 1, 0);

        // Silent device
        c = int'($urandom_range(0, 1));
        gen(2, 0);
        run_txn(arb(c == 1 ? 2'b10 : 2'b01, last_owner), 1, -1, 0);

        // Receive error, concurrent byte dropped
        c = int'($urandom_range(0, 1));
        gen(3, 3);
        run_txn(arb(c == 1 ? 2'b10 : 2'b01, last_owner), 2, -1, 0);

        // Reset in the middle of SEND
        c = int'($urandom_range(0, 1));
        gen(2, 0);
        base_dn = done_log.size();
        bus.req[c] = 1'b1;
        for (k = 0; k < 50; k++) begin
            @(negedge clk);
            if (bus.grant != 2'b00) break;
        end
        step();
        bus.req[c] = 1'b0;
        bus.cmd_data[8*c +: 8] = cmd_q[0];
        bus.cmd_valid[c] = 1'b1;
        for (k = 0; k < 100; k++) begin
            @(negedge clk);
            if (bus.cmd_ready[c]) break;
        end
        step();
        bus.cmd_data[8*c +: 8] = cmd_q[1];
        reset = 1'b0;
        step();
        @(negedge clk);
        chk("rst_mid_grant", 32'(bus.grant), 32'd0);
        chk("rst_mid_busy", 32'(bus.busy), 32'd0);
        chk("rst_mid_status", 32'(bus.status), 32'd0);
        chk("rst_mid_pulses", 32'({bus.done, bus.rsp_valid}), 32'd0);
        chk("rst_mid_uart", 32'({bus.wr_uart, bus.rd_uart, bus.cmd_ready}), 32'd0);
        chk("rst_mid_no_done", 32'(done_log.size() - base_dn), 32'd0);
        bus.cmd_valid = 2'b00;
        step();
        reset = 1'b1;
        last_owner = 1;
        bus.req = 2'b11;

        // Both clients request together: round-robin alternation
        gen(2, 2);
        run_txn(arb(2'b11, last_owner), 0, -1, 0);
        gen(3, 1);
        run_txn(arb(2'b10, last_owner), 0, -1, 0);
        bus.req = 2'b11;
        gen(1, 3);
        run_txn(arb(2'b11, last_owner), 0, -1, 0);
        gen(2, 2);
        run_txn(arb(2'b10, last_owner), 2, -1, 0);

        // Random traffic
        for (int t = 0; t < 5; t++) begin
            m = int'($urandom_range(0, 2));
            c = int'($urandom_range(0, 1));
            gen(int'($urandom_range(1, 5)), (m == 1) ? 0 : int'($urandom_range(0, 5)));
            run_txn(arb(c == 1 ? 2'b10 : 2'b01, last_owner), m,
                    ($urandom_range(0, 1) == 1) ? 1 : -1, 0);
        end

        chk("invariants", 32'(bad), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_cmd_ctrl.md
Name: uart_cmd_ctrl

Overview:
Transaction controller that shares one uart instance (FIFO-buffered tx/rx) between two requesters. A transaction is one command and its response. The granted requester streams command bytes into the UART TX FIFO until a terminator byte. The block then drains RX bytes back to that requester until a prompt byte, a timeout or a receive error. It sits between the uart and the gauge/OBD command logic.

Parameters:
TERM_TX, 8'h0D, command terminator byte; written to the UART, ends the SEND phase
PROMPT, 8'h3E, response-end byte; consumed and not forwarded
TIMEOUT, 500000, idle cycles without an RX byte before the block aborts RECV
TO_W, 20, timeout counter width; must satisfy 2^TO_W > TIMEOUT

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low reset
req  in  2  per-client transaction request; bit i is client i
cmd_data  in  16  command bytes; [8i+7:8i] belongs to client i
cmd_valid  in  2  per-client command byte valid
cmd_ready  out  2  per-client command byte accepted
rsp_data  out  8  response byte, shared by both clients
rsp_valid  out  2  one-cycle pulse to the granted client
done  out  2  one-cycle end-of-transaction pulse to the granted client
status  out  2  00 ok, 01 timeout, 10 rx error; valid with done and held until the next done
grant  out  2  one-hot current owner, 00 when idle
busy  out  1  high in any state other than IDLE
wr_uart  out  1  UART TX FIFO push
w_data  out  8  UART write data
tx_full  in  1  UART TX FIFO full
rd_uart  out  1  UART RX FIFO pop
r_data  in  8  UART RX FIFO head; valid whenever rx_empty=0 (read-ahead FIFO)
rx_empty  in  1  UART RX FIFO empty
e_parity, e_frame, e_rxof  in  1 each  UART error pulses

Behaviour:
- Reset (reset=0 at a clk edge):
  - state=IDLE; all outputs 0; status=00; last_grant=1, so client 0 wins first.
  - UART FIFO contents are not touched. Reset mid-transaction aborts it with no done pulse.
- IDLE:
  - If req != 0: pref = ~last_grant. Grant pref if req[pref]=1, else grant the other client.
  - Register grant, then go to FLUSH. grant and busy assert on the next cycle.
- FLUSH:
  - While rx_empty=0: rd_uart=1 and the byte is discarded; no rsp_valid.
  - When rx_empty=1: go to SEND. Error pulses are ignored in FLUSH.
- SEND (g = granted client):
  - cmd_ready[g] = ~tx_full, combinational. cmd_ready of the other client is 0.
  - Transfer when cmd_valid[g] & cmd_ready[g]: wr_uart=1 and w_data=cmd_data[g] in the same cycle, combinational pass-through.
  - If the transferred byte equals TERM_TX: it is written, the timer is cleared, next state is RECV.
  - tx_full=1 gives no write and no acceptance; the state is held indefinitely.
- RECV:
  - Timer increments every cycle.
  - When rx_empty=0: rd_uart=1 and the timer clears.
    - If r_data != PROMPT: the byte is registered to rsp_data and rsp_valid[g] pulses on the next cycle. Latency is 1 cycle from pop.
    - If r_data == PROMPT: it is popped, not forwarded; go to DONE with status 00.
  - Any of e_parity, e_frame or e_rxof high: go to DONE with status 10. This has priority over PROMPT in the same cycle. The concurrent byte is still popped but not forwarded.
  - Timer == TIMEOUT-1 with rx_empty=1: go to DONE with status 01. A byte arriving in the timeout cycle wins and the timer clears.
- DONE (one cycle):
  - done[g]=1 and status updated.
  - last_grant=g, grant cleared, next state IDLE.
  - A client still holding req re-arbitrates under the round-robin rule.
- Requests:
  - Deasserting req[g] mid-transaction is ignored; the transaction completes.
  - A non-granted client's cmd_valid is ignored.
- Outputs wr_uart, rd_uart, cmd_ready and w_data are combinational from state and inputs. All others are registered.

Test Plan:
- Client 0 only, cmd 0x41,0x54,0x0D with tx_full=0; RX stub returns 0x4F,0x4B,0x3E -> wr_uart pulses with w_data 41,54,0D; rsp_valid[0] twice with rsp_data 4F then 4B; done[0]=1 with status=00; grant returns to 00.
- req=11 in the same cycle after reset -> grant=01, then after done grant=10; raise req=11 again -> grant=01.
- Two stale 0x55 bytes in RX before the request -> two rd_uart pulses in FLUSH, no rsp_valid, then SEND begins.
- TIMEOUT=100 (bench override), no RX bytes -> done with status=01 exactly 100 cycles after the 0x0D write cycle.
- tx_full=1 for 10 cycles mid-command -> cmd_ready[g]=0 and no wr_uart for those 10 cycles; the next byte is written on the first cycle tx_full=0; no bytes lost or duplicated.
- e_frame pulse during RECV -> done with status=10 the next cycle.
- reset=0 during SEND -> next edge: grant=00, busy=0, all outputs 0, no done pulse.
